pipe_addsub: RTL and testbench
==============================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 Parameter WIDTH SHALL default to 8 and set the operand width; WIDTH >= 2.
REQ-003 Parameter STAGES SHALL default to 2 and set the pipeline depth; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: operation offered.
REQ-007 Port in_ready, output, 1: operation accepted when in_valid && in_ready.
REQ-008 Port op, input, 2: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-009 Port a and port b, input, WIDTH each: operands.
REQ-010 Port flag_clr, input, 1: synchronous clear of the stored carry flag.
REQ-011 Port out_valid, output, 1: result available.
REQ-012 Port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-013 Port res, output, WIDTH: sum or difference.
REQ-014 Port flags, output, 4: {C, V, N, Z} belonging to res.
REQ-015 Port carry_flag, output, 1: stored carry flag register.

Function
REQ-016 Arithmetic SHALL be ADD a+b+0, SUB a+~b+1, ADC a+b+carry_flag, SBC a+~b+carry_flag, all modulo 2^WIDTH.
REQ-017 C SHALL be the carry out of bit WIDTH-1; for SUB, C=1 means no borrow.
REQ-018 V SHALL be the signed overflow, carry into MSB XOR carry out of MSB; N = res[WIDTH-1]; Z = (res == 0).
REQ-019 The carry chain SHALL be split into STAGES segments of WIDTH/STAGES bits. Segment k SHALL be computed in stage k, with its carry registered into stage k+1. Unprocessed upper operand bits SHALL travel with the pipeline.
REQ-020 Latency SHALL be exactly STAGES cycles from input handshake to out_valid when there is no stall. Throughput SHALL be one operation per cycle.
REQ-021 Stall: while out_valid && !out_ready, every stage SHALL hold. Results SHALL be neither lost, duplicated nor reordered.
REQ-022 in_ready SHALL be !(out_valid && !out_ready) && !hazard.
REQ-023 hazard SHALL be 1 when op is ADC or SBC and any pipeline stage holds a valid operation; this interlock is combinational on op.
REQ-024 carry_flag SHALL load C on each output handshake.
REQ-025 ADC and SBC SHALL sample carry_flag at input handshake.
REQ-026 flag_clr SHALL force carry_flag to 0 next cycle. If it coincides with an output handshake, flag_clr SHALL win.
REQ-027 in_valid low SHALL insert a bubble; bubbles SHALL NOT update carry_flag.
REQ-028 With STAGES==1, the single stage SHALL compute all bits and latency SHALL be 1.

Reset
REQ-029 On rst_n low, all stage valid bits, out_valid, res, flags and carry_flag SHALL be 0 immediately; in_ready SHALL be 1 while in reset.
REQ-030 Operations in flight at reset SHALL be discarded. The first operation after release SHALL behave as from a cold start.

Structure
REQ-031 A shared package SHALL hold the op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC) and the flag bit indices (FLAG_C, FLAG_V, FLAG_N, FLAG_Z).
REQ-032 One sub-module, addsub_seg, SHALL implement a combinational ripple segment (parameter SEG, inputs a, b, cin, invert; outputs sum, cout, and carry into the top bit). It SHALL be instantiated once per stage.
REQ-033 Stage registers and handshake logic SHALL live in pipe_addsub.

Verification (WIDTH=8, STAGES=2)
REQ-034 ADD 0x7F+0x01 -> 2 cycles later res=0x80, C=0, V=1, N=1, Z=0.
REQ-035 SUB 0x05-0x05 -> res=0x00, C=1, V=0, N=0, Z=1; then SUB 0x00-0x01 -> res=0xFF, C=0, N=1.
REQ-036 ADD 0xFF+0x01 (C=1) followed immediately by ADC 0x00+0x00 -> in_ready low until ADD completes; ADC result res=0x01, carry_flag=0 afterwards.
REQ-037 Stream 4 ADDs (1+1, 2+2, 3+3, 4+4) with out_ready low for 3 cycles mid-stream -> outputs 0x02, 0x04, 0x06, 0x08 in order, each exactly once.
REQ-038 Assert rst_n low while 2 operations are in flight -> out_valid=0, carry_flag=0 immediately; no stale result appears after release.
REQ-039 flag_clr in the same cycle as a C=1 output handshake -> carry_flag=0.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Holds the op encodings, the flag bit positions inside the flags
// vector, and a helper that identifies carry-consuming ops.
package pipe_addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  // Bit positions inside flags = {C, V, N, Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  localparam int FLAG_W = 4;

  // ADC/SBC read the stored carry flag, so they must wait for an empty pipe
  function automatic logic op_uses_carry(input logic [1:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/pipe_addsub_seg.sv
// Purpose: combinational ripple-carry segment of SEG bits, optional b inversion.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage decides when to capture.
// Ports: a, b      - segment operand bits
//        cin       - carry into bit 0 of the segment
//        invert    - use ~b instead of b (subtract forms)
//        sum       - segment result bits
//        cout      - carry out of the segment's top bit
//        cmsb      - carry into the segment's top bit (for signed overflow)
module addsub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           invert,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG-1:0] b_eff;
  logic [SEG:0]   c;

  assign b_eff = invert ? ~b : b;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipe_addsub.sv
// Purpose: pipelined ADD/SUB/ADC/SBC, carry chain split into STAGES ripple segments.
// Latency: STAGES cycles input handshake to out_valid, one op per cycle.
// Backpressure: whole pipe holds while out_valid && !out_ready; ADC/SBC wait for an empty pipe.
// Ports: clk, rst_n              - clock, async active-low reset
//        in_valid/in_ready, op, a, b - operation offer and handshake
//        flag_clr                - synchronous clear of the stored carry flag
//        out_valid/out_ready, res, flags - result {C,V,N,Z} and handshake
//        carry_flag              - carry flag register, loaded from C on each output handshake
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              flag_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  res,
  output logic [FLAG_W-1:0] flags,
  output logic              carry_flag
);

  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] stage_vld;
  logic              advance;
  logic              hazard;
  logic              in_fire;
  logic              out_fire;
  logic              first_cin;
  logic [WIDTH-1:0]  res_q;
  logic [FLAG_W-1:0] flags_q;
  logic              carry_q;

  assign out_valid  = stage_vld[STAGES-1];
  assign res        = res_q;
  assign flags      = flags_q;
  assign carry_flag = carry_q;

  // Every stage moves together; a stalled output freezes the whole pipe
  assign advance  = !(out_valid && !out_ready);
  // Carry-consuming ops must see the carry of every older op already retired
  assign hazard   = op_uses_carry(op) && (|stage_vld);
  assign in_ready = advance && !hazard;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    first_cin = 1'b0;
    case (op)
      OP_ADD:  first_cin = 1'b0;
      OP_SUB:  first_cin = 1'b1;
      default: first_cin = carry_q;
    endcase
  end

  // Stored carry; a clear request beats a coincident output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (flag_clr) begin
      carry_q <= 1'b0;
    end else if (out_fire) begin
      carry_q <= flags_q[FLAG_C];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SEG;

    logic [SEG-1:0]  seg_a;
    logic [SEG-1:0]  seg_b;
    logic [SEG-1:0]  seg_sum;
    logic            seg_cin;
    logic            seg_inv;
    logic            seg_in_vld;
    logic            seg_cout;
    logic            seg_cmsb;
    logic [DONE-1:0] acc;
    logic            vld_q;

    // Stage 0 eats the port operands; later stages eat the bits carried along
    if (k == 0) begin : g_src
      assign seg_a      = a[SEG-1:0];
      assign seg_b      = b[SEG-1:0];
      assign seg_cin    = first_cin;
      assign seg_inv    = op[0];
      assign seg_in_vld = in_fire;
      assign acc        = seg_sum;
    end else begin : g_src
      assign seg_a      = g_stage[k-1].g_mid.rem_a_q[SEG-1:0];
      assign seg_b      = g_stage[k-1].g_mid.rem_b_q[SEG-1:0];
      assign seg_cin    = g_stage[k-1].g_mid.cy_q;
      assign seg_inv    = g_stage[k-1].g_mid.inv_q;
      assign seg_in_vld = stage_vld[k-1];
      assign acc        = {seg_sum, g_stage[k-1].g_mid.sum_q};
    end

    addsub_seg #(
      .SEG(SEG)
    ) u_seg (
      .a      (seg_a),
      .b      (seg_b),
      .cin    (seg_cin),
      .invert (seg_inv),
      .sum    (seg_sum),
      .cout   (seg_cout),
      .cmsb   (seg_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= seg_in_vld;
      end
    end

    assign stage_vld[k] = vld_q;

    if (k < STAGES - 1) begin : g_mid
      localparam int REM = WIDTH - DONE;

      logic [DONE-1:0] sum_q;
      logic [REM-1:0]  rem_a_q;
      logic [REM-1:0]  rem_b_q;
      logic [REM-1:0]  rem_a_d;
      logic [REM-1:0]  rem_b_d;
      logic            cy_q;
      logic            inv_q;
      logic            unused_cmsb;

      // Only the final segment's top-bit carry matters for overflow
      assign unused_cmsb = seg_cmsb;

      if (k == 0) begin : g_rem_src
        assign rem_a_d = a[WIDTH-1:SEG];
        assign rem_b_d = b[WIDTH-1:SEG];
      end else begin : g_rem_src
        assign rem_a_d = g_stage[k-1].g_mid.rem_a_q[REM+SEG-1:SEG];
        assign rem_b_d = g_stage[k-1].g_mid.rem_b_q[REM+SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q   <= '0;
          rem_a_q <= '0;
          rem_b_q <= '0;
          cy_q    <= 1'b0;
          inv_q   <= 1'b0;
        end else if (advance) begin
          sum_q   <= acc;
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
          cy_q    <= seg_cout;
          inv_q   <= seg_inv;
        end
      end
    end else begin : g_last
      // Result and flags only change when a real op arrives, bubbles leave them alone
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q   <= '0;
          flags_q <= '0;
        end else if (advance && seg_in_vld) begin
          res_q           <= acc;
          flags_q[FLAG_C] <= seg_cout;
          flags_q[FLAG_V] <= seg_cout ^ seg_cmsb;
          flags_q[FLAG_N] <= acc[WIDTH-1];
          flags_q[FLAG_Z] <= (acc == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub at WIDTH=8, STAGES=2.
// Each scenario task drives its own vectors and checks against hand-computed values.
// Summary line reports total checks and errors.
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flag_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [3:0]       flags;
  logic             carry_flag;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .flag_clr   (flag_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res        (res),
    .flags      (flags),
    .carry_flag (carry_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL reset_res: got %h expected 00", res); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    drive(OP_ADD, 8'h7F, 8'h01);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got %b expected 1", out_valid); end
    checks++; if (res !== 8'h80) begin errors++; $display("FAIL add_res: got %h expected 80", res); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL add_flags: got %b expected 0110", flags); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_retire: got %b expected 0", out_valid); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL add_carry: got %b expected 0", carry_flag); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive(OP_SUB, 8'h05, 8'h05);
    tick();
    drive(OP_SUB, 8'h00, 8'h01);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL sub_zero_res: got %h expected 00", res); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL sub_zero_flags: got %b expected 1001", flags); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_b2b_valid: got %b expected 1", out_valid); end
    checks++; if (res !== 8'hFF) begin errors++; $display("FAIL sub_borrow_res: got %h expected ff", res); end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL sub_borrow_flags: got %b expected 0010", flags); end
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL sub_carry_load: got %b expected 1", carry_flag); end
    tick();
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL sub_carry_after: got %b expected 0", carry_flag); end
  endtask

  task automatic test_adc_hazard();
    out_ready = 1'b1;
    drive(OP_ADD, 8'hFF, 8'h01);
    tick();
    drive(OP_ADC, 8'h00, 8'h00);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL adc_hazard_s0: got %b expected 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL adc_hazard_s1: got %b expected 0", in_ready); end
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL adc_pre_res: got %h expected 00", res); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL adc_pre_flags: got %b expected 1001", flags); end
    tick();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL adc_carry_in: got %b expected 1", carry_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL adc_ready_empty: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL adc_valid: got %b expected 1", out_valid); end
    checks++; if (res !== 8'h01) begin errors++; $display("FAIL adc_res: got %h expected 01", res); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL adc_flags: got %b expected 0000", flags); end
    tick();
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL adc_carry_after: got %b expected 0", carry_flag); end
  endtask

  task automatic test_sbc();
    out_ready = 1'b1;
    drive(OP_SBC, 8'h05, 8'h03);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (res !== 8'h01) begin errors++; $display("FAIL sbc_res: got %h expected 01", res); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL sbc_flags: got %b expected 1000", flags); end
    tick();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL sbc_carry: got %b expected 1", carry_flag); end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected 0", carry_flag); end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] exp_res [4];
    int sent;
    int got;
    logic fire_in;
    logic fire_out;
    exp_res[0] = 8'h02; exp_res[1] = 8'h04; exp_res[2] = 8'h06; exp_res[3] = 8'h08;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = (sent < 4);
      op        = OP_ADD;
      a         = 8'(sent + 1);
      b         = 8'(sent + 1);
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (cyc == 4) begin
        checks++; if (out_valid !== 1'b1 || res !== 8'h04) begin errors++; $display("FAIL stall_hold: got valid=%b res=%h expected valid=1 res=04", out_valid, res); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      end
      if (fire_out) begin
        if (got < 4) begin
          checks++; if (res !== exp_res[got]) begin errors++; $display("FAIL stream_res%0d: got %h expected %h", got, res, exp_res[got]); end
        end
        got++;
      end
      tick();
      if (fire_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 4) begin errors++; $display("FAIL stream_count: got %0d expected 4", got); end
    checks++; if (sent !== 4) begin errors++; $display("FAIL stream_sent: got %0d expected 4", sent); end
  endtask

  task automatic test_flag_clr();
    out_ready = 1'b1;
    drive(OP_ADD, 8'hFF, 8'h02);
    tick();
    in_valid = 1'b0;
    tick();
    flag_clr = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || flags[FLAG_C] !== 1'b1) begin errors++; $display("FAIL clr_setup: got valid=%b C=%b expected 1 1", out_valid, flags[FLAG_C]); end
    tick();
    flag_clr = 1'b0;
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL clr_wins: got %b expected 0", carry_flag); end
  endtask

  task automatic test_reset_flight();
    logic seen;
    out_ready = 1'b1;
    drive(OP_ADD, 8'h80, 8'h80);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL rf_carry_setup: got %b expected 1", carry_flag); end
    out_ready = 1'b0;
    drive(OP_ADD, 8'h10, 8'h10);
    tick();
    drive(OP_ADD, 8'h20, 8'h20);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_in_flight: got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid: got %b expected 0", out_valid); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL rf_carry: got %b expected 0", carry_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready: got %b expected 1", in_ready); end
    checks++; if (res !== 8'h00 || flags !== 4'b0000) begin errors++; $display("FAIL rf_res_flags: got res=%h flags=%b expected 00 0000", res, flags); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rf_stale: got %b expected 0", seen); end
    drive(OP_ADD, 8'h03, 8'h04);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cold_early: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || res !== 8'h07) begin errors++; $display("FAIL cold_res: got valid=%b res=%h expected 1 07", out_valid, res); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL cold_flags: got %b expected 0000", flags); end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    flag_clr  = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub();
    test_adc_hazard();
    test_sbc();
    test_back_to_back_stall();
    test_flag_clr();
    test_reset_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
